// File: rtl/controller_poll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// controller_pkg : poll sequencer states and CPU register map
// Rev 1.0
// ----------------------------------------------------------------------------
package controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } poll_state_t;

  localparam int CTRL_DATA_W = 8;
  localparam int CTRL_ADDR_W = 3;

  localparam logic [CTRL_ADDR_W-1:0] CTRL_ADDR_CUR_1     = 3'd0;
  localparam logic [CTRL_ADDR_W-1:0] CTRL_ADDR_CUR_2     = 3'd1;
  localparam logic [CTRL_ADDR_W-1:0] CTRL_ADDR_PRESSED_1 = 3'd2;
  localparam logic [CTRL_ADDR_W-1:0] CTRL_ADDR_PRESSED_2 = 3'd3;
  localparam logic [CTRL_ADDR_W-1:0] CTRL_ADDR_STATUS    = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controller_poll_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// controller_poll_if : pad-interface and CPU register-bus signals of the poll block
// Rev 1.0
// ----------------------------------------------------------------------------
interface controller_poll_if;
  import controller_pkg::*;

  logic                   vblank_start;
  logic                   start_fetch;
  logic [CTRL_DATA_W-1:0] ctrl_1_data_in;
  logic [CTRL_DATA_W-1:0] ctrl_2_data_in;
  logic [CTRL_ADDR_W-1:0] cpu_addr;
  logic                   cpu_rd;
  logic [CTRL_DATA_W-1:0] cpu_rdata;

  modport master (
    output vblank_start, ctrl_1_data_in, ctrl_2_data_in, cpu_addr, cpu_rd,
    input  start_fetch, cpu_rdata
  );

  modport slave (
    input  vblank_start, ctrl_1_data_in, ctrl_2_data_in, cpu_addr, cpu_rd,
    output start_fetch, cpu_rdata
  );
endinterface
`default_nettype wire

// File: rtl/controller_poll_edge_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// controller_edge_tracker : one player's current buttons and sticky newly-pressed bits
// Rev 1.0
// ----------------------------------------------------------------------------
module controller_edge_tracker
  import controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture,
  input  logic                   rd_clear,
  input  logic [CTRL_DATA_W-1:0] data_in,
  output logic [CTRL_DATA_W-1:0] cur,
  output logic [CTRL_DATA_W-1:0] pressed
);

  logic [CTRL_DATA_W-1:0] pressed_next;

  // Clear first, then OR in new edges so a read racing a capture loses nothing.
  always_comb begin
    pressed_next = rd_clear ? '0 : pressed;
    if (capture) begin
      pressed_next = pressed_next | (data_in & ~cur);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      pressed <= '0;
    end else begin
      pressed <= pressed_next;
      if (capture) begin
        cur <= data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/controller_poll.sv
`default_nettype none
// ----------------------------------------------------------------------------
// controller_poll : per-vblank controller poll sequencer and CPU register bank
// Rev 1.0
// ----------------------------------------------------------------------------
module controller_poll
  import controller_pkg::*;
#(
  parameter int FETCH_PULSE_CYCLES = 2,
  parameter int SETTLE_CYCLES      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  controller_poll_if.slave  bus
);

  if (FETCH_PULSE_CYCLES < 1 || FETCH_PULSE_CYCLES > 9) begin : g_bad_fetch_pulse
    $error("controller_poll: FETCH_PULSE_CYCLES must be in 1..9");
  end
  if (SETTLE_CYCLES < 10) begin : g_bad_settle
    $error("controller_poll: SETTLE_CYCLES must be >= 10");
  end

  localparam int CNT_W = $clog2(max_int(FETCH_PULSE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'(FETCH_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  poll_state_t            state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   start_fetch_r;
  logic                   capture;
  logic                   valid, overrun;
  logic                   rd_pressed_1, rd_pressed_2, rd_status;
  logic [CTRL_DATA_W-1:0] cur_1, cur_2, pressed_1, pressed_2;
  logic [CTRL_DATA_W-1:0] rd_mux, rdata_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      start_fetch_r <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      start_fetch_r <= (state_next == FETCH);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.vblank_start) state_next = FETCH;
      end
      FETCH: begin
        if (cnt == FETCH_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (cnt == SETTLE_LAST) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign capture      = (state == CAPTURE);
  assign rd_pressed_1 = bus.cpu_rd && (bus.cpu_addr == CTRL_ADDR_PRESSED_1);
  assign rd_pressed_2 = bus.cpu_rd && (bus.cpu_addr == CTRL_ADDR_PRESSED_2);
  assign rd_status    = bus.cpu_rd && (bus.cpu_addr == CTRL_ADDR_STATUS);

  controller_edge_tracker u_player_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .rd_clear (rd_pressed_1),
    .data_in  (bus.ctrl_1_data_in),
    .cur      (cur_1),
    .pressed  (pressed_1)
  );

  controller_edge_tracker u_player_2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .rd_clear (rd_pressed_2),
    .data_in  (bus.ctrl_2_data_in),
    .cur      (cur_2),
    .pressed  (pressed_2)
  );

  // overrun flags a capture landing while the previous one was still unread.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (capture) begin
      valid   <= 1'b1;
      overrun <= rd_status ? 1'b0 : (overrun | valid);
    end else if (rd_status) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.cpu_addr)
      CTRL_ADDR_CUR_1:     rd_mux = cur_1;
      CTRL_ADDR_CUR_2:     rd_mux = cur_2;
      CTRL_ADDR_PRESSED_1: rd_mux = pressed_1;
      CTRL_ADDR_PRESSED_2: rd_mux = pressed_2;
      CTRL_ADDR_STATUS:    rd_mux = {6'b0, overrun, valid};
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (bus.cpu_rd) begin
      rdata_r <= rd_mux;
    end
  end

  assign bus.start_fetch = start_fetch_r;
  assign bus.cpu_rdata   = rdata_r;

endmodule
`default_nettype wire

// File: tb/tb_controller_poll.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_controller_poll : directed bench with a behavioural pad shift interface
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_controller_poll;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  controller_poll_if bus ();

  controller_poll #(
    .FETCH_PULSE_CYCLES (2),
    .SETTLE_CYCLES      (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural controller_interface_m: latch pads while start_fetch is high,
  // then shift 8 bits out one per clock and publish the assembled bytes.
  logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
  logic [7:0] sh1 = 8'h00, sh2 = 8'h00, acc1 = 8'h00, acc2 = 8'h00;
  logic [3:0] bitcnt = 4'd0;

  always @(posedge clk) begin
    if (bus.start_fetch) begin
      sh1    <= pad1;
      sh2    <= pad2;
      bitcnt <= 4'd8;
    end else if (bitcnt != 4'd0) begin
      sh1    <= {sh1[6:0], 1'b0};
      sh2    <= {sh2[6:0], 1'b0};
      acc1   <= {acc1[6:0], sh1[7]};
      acc2   <= {acc2[6:0], sh2[7]};
      bitcnt <= bitcnt - 4'd1;
      if (bitcnt == 4'd1) begin
        bus.ctrl_1_data_in <= {acc1[6:0], sh1[7]};
        bus.ctrl_2_data_in <= {acc2[6:0], sh2[7]};
      end
    end
  end

  // start_fetch activity monitor
  int   sf_high  = 0;
  int   sf_rises = 0;
  logic sf_d     = 1'b0;
  always @(negedge clk) begin
    sf_d <= bus.start_fetch;
    if (bus.start_fetch) sf_high <= sf_high + 1;
    if (bus.start_fetch && !sf_d) sf_rises <= sf_rises + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_vblank();
    bus.vblank_start = 1'b1;
    @(negedge clk);
    bus.vblank_start = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] addr, output logic [7:0] data);
    bus.cpu_addr = addr;
    bus.cpu_rd   = 1'b1;
    @(negedge clk);
    bus.cpu_rd   = 1'b0;
    data         = bus.cpu_rdata;
  endtask

  task automatic poll(input logic [7:0] p1, input logic [7:0] p2);
    pad1 = p1;
    pad2 = p2;
    pulse_vblank();
    tick(18);
  endtask

  // Read issued so that its strobe is sampled on the CAPTURE edge (15 cycles after vblank).
  task automatic poll_read_at_capture(input logic [7:0] p1, input logic [7:0] p2,
                                      input logic [2:0] addr, output logic [7:0] data);
    pad1 = p1;
    pad2 = p2;
    pulse_vblank();
    tick(14);
    cpu_read(addr, data);
    tick(3);
  endtask

  logic [7:0] rd;
  int         rises0, high0;

  initial begin
    bus.vblank_start = 1'b0;
    bus.cpu_rd       = 1'b0;
    bus.cpu_addr     = 3'd0;

    // Reset state
    tick(2);
    check("reset_start_fetch", {7'b0, bus.start_fetch}, 8'h00);
    check("reset_rdata", bus.cpu_rdata, 8'h00);
    rst_n = 1'b1;
    tick(1);
    cpu_read(3'd4, rd); check("reset_status", rd, 8'h00);
    cpu_read(3'd0, rd); check("reset_cur1", rd, 8'h00);

    // Reset in the middle of FETCH aborts the poll
    pad1 = 8'hFF;
    pad2 = 8'hFF;
    pulse_vblank();
    check("fetch_started", {7'b0, bus.start_fetch}, 8'h01);
    #2 rst_n = 1'b0;
    #1 check("abort_start_fetch", {7'b0, bus.start_fetch}, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    rises0 = sf_rises;
    tick(20);
    check("abort_no_refetch", 8'(sf_rises - rises0), 8'h00);
    cpu_read(3'd4, rd); check("abort_no_capture", rd, 8'h00);

    // Basic poll: pulse width and captured bytes
    rises0 = sf_rises;
    high0  = sf_high;
    pad1   = 8'hA5;
    pad2   = 8'h3C;
    pulse_vblank();
    tick(16);
    check("poll_fetch_cycles", 8'(sf_high - high0), 8'h02);
    check("poll_fetch_pulses", 8'(sf_rises - rises0), 8'h01);
    cpu_read(3'd0, rd); check("cur1_A5", rd, 8'hA5);
    cpu_read(3'd1, rd); check("cur2_3C", rd, 8'h3C);
    cpu_read(3'd4, rd); check("status_valid", rd, 8'h01);
    cpu_read(3'd5, rd); check("addr5_zero", rd, 8'h00);
    cpu_read(3'd7, rd); check("addr7_zero", rd, 8'h00);
    cpu_read(3'd2, rd); check("pressed1_first", rd, 8'hA5);
    cpu_read(3'd3, rd); check("pressed2_first", rd, 8'h3C);

    // Idle pads, then edge tracking across two polls
    poll(8'h00, 8'h00);
    cpu_read(3'd2, rd); check("pressed1_idle", rd, 8'h00);
    cpu_read(3'd4, rd); check("status_idle", rd, 8'h01);
    poll(8'h01, 8'h00);
    cpu_read(3'd2, rd); check("pressed1_01", rd, 8'h01);
    poll(8'h03, 8'h00);
    cpu_read(3'd2, rd); check("pressed1_02", rd, 8'h02);
    cpu_read(3'd2, rd); check("pressed1_reread", rd, 8'h00);
    cpu_read(3'd1, rd); check("cur2_00", rd, 8'h00);

    // Two captures without a status read set overrun
    cpu_read(3'd4, rd); check("status_overrun", rd, 8'h03);
    cpu_read(3'd4, rd); check("status_cleared", rd, 8'h00);

    // Clear-on-read of pressed racing a capture
    poll(8'h00, 8'h00);
    poll(8'h01, 8'h00);
    poll_read_at_capture(8'h11, 8'h00, 3'd2, rd);
    check("race_pressed_old", rd, 8'h01);
    cpu_read(3'd2, rd); check("race_pressed_new", rd, 8'h10);
    cpu_read(3'd0, rd); check("race_cur1", rd, 8'h11);
    cpu_read(3'd4, rd); check("race_status", rd, 8'h03);

    // Clear-on-read of status racing a capture
    poll(8'h11, 8'h00);
    poll_read_at_capture(8'h11, 8'h00, 3'd4, rd);
    check("status_race_old", rd, 8'h01);
    cpu_read(3'd4, rd); check("status_race_new", rd, 8'h01);
    cpu_read(3'd4, rd); check("status_race_clear", rd, 8'h00);

    // vblank_start during WAIT is ignored
    rises0 = sf_rises;
    high0  = sf_high;
    pad1   = 8'h80;
    pulse_vblank();
    tick(5);
    pulse_vblank();
    tick(25);
    check("wait_vblank_pulses", 8'(sf_rises - rises0), 8'h01);
    check("wait_vblank_cycles", 8'(sf_high - high0), 8'h02);
    cpu_read(3'd0, rd); check("wait_vblank_cur1", rd, 8'h80);
    cpu_read(3'd4, rd); check("wait_vblank_status", rd, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
